// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the note parser slice.
//   - status-kind constants (upper nibble of a channel status byte)
//   - t_parse_state : byte-parser FSM states
//   - t_note_event  : one buffered note event {note_on, note_num, velocity}
//   - has_one_data  : true for kinds that carry a single data byte
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHAN_AT  = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  typedef enum logic [1:0] {
    S_WAIT_STATUS = 2'd0,
    S_WAIT_DATA1  = 2'd1,
    S_WAIT_DATA2  = 2'd2
  } t_parse_state;

  typedef struct packed {
    logic       note_on;
    logic [6:0] note_num;
    logic [6:0] velocity;
  } t_note_event;

  function automatic logic has_one_data(input logic [3:0] kind);
    return (kind == ST_PROG) || (kind == ST_CHAN_AT);
  endfunction

endpackage

// File: rtl/midi_event_fifo.sv
// Synchronous FIFO of note events.
//   clk, reset_n : clock, asynchronous active-low reset (empties and zeroes storage)
//   push, din    : write request and event; accepted when not full, or when
//                  a pop is accepted in the same cycle
//   pop          : read request; ignored while empty
//   empty, full  : occupancy flags decoded from the registered count
//   head         : oldest stored event
import midi_pkg::*;

module midi_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  t_note_event din,
  input  logic        pop,
  output logic        empty,
  output logic        full,
  output t_note_event head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  t_note_event   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic do_pop;
  logic do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage is reset as well as the pointers, so head reads as zero
  // after reset instead of exposing stale events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;  // power-of-two depth: wraps naturally
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/midi_note_parser.sv
// MIDI byte parser: decodes note-on / note-off on one channel (with running
// status) and queues events for poly2mono.
//   clk, reset_n  : clock, asynchronous active-low reset
//   byte_valid    : one-cycle strobe qualifying byte_data
//   byte_data     : received MIDI byte
//   ready         : downstream accepts the head event
//   valid_out     : head event available
//   note_on_out   : head event is note-on (1) or note-off (0)
//   note_num_out  : head event note number
//   velocity_out  : head event velocity
//   overflow      : one-cycle pulse when a completed event found the FIFO full
import midi_pkg::*;

module midi_note_parser #(
  parameter int CHANNEL    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       ready,
  output logic       valid_out,
  output logic       note_on_out,
  output logic [6:0] note_num_out,
  output logic [6:0] velocity_out,
  output logic       overflow
);

  localparam logic [3:0] CHAN = 4'(CHANNEL);

  t_parse_state state;
  logic [3:0]   rs_kind;
  logic [3:0]   rs_chan;
  logic [6:0]   data1;

  logic is_sys;
  logic is_chan;
  logic is_data;
  logic push_evt;
  logic pop_evt;
  logic fifo_empty;
  logic fifo_full;
  t_note_event new_evt;
  t_note_event head_evt;

  // Real-time bytes (0xF8-0xFF) match none of these and leave everything untouched.
  assign is_sys  = byte_valid & (byte_data[7:3] == 5'b11110);
  assign is_chan = byte_valid & byte_data[7] & (byte_data[7:4] != 4'hF);
  assign is_data = byte_valid & ~byte_data[7];

  // The second data byte goes straight into the FIFO, so the event is visible
  // the cycle after the strobe.
  assign push_evt = is_data && (state == S_WAIT_DATA2) &&
                    ((rs_kind == ST_NOTE_ON) || (rs_kind == ST_NOTE_OFF)) &&
                    (rs_chan == CHAN);

  assign new_evt = '{note_on:  (rs_kind == ST_NOTE_ON),
                     note_num: data1,
                     velocity: byte_data[6:0]};

  assign valid_out = ~fifo_empty;
  assign pop_evt   = valid_out & ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAIT_STATUS;
      rs_kind  <= '0;
      rs_chan  <= '0;
      data1    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_evt & fifo_full & ~pop_evt;
      if (is_sys) begin
        state   <= S_WAIT_STATUS;
        rs_kind <= '0;
        rs_chan <= '0;
      end else if (is_chan) begin
        // A status byte mid-message simply abandons the partial message.
        state   <= S_WAIT_DATA1;
        rs_kind <= byte_data[7:4];
        rs_chan <= byte_data[3:0];
      end else if (is_data) begin
        case (state)
          S_WAIT_STATUS: state <= S_WAIT_STATUS;
          S_WAIT_DATA1: begin
            data1 <= byte_data[6:0];
            if (!has_one_data(rs_kind)) state <= S_WAIT_DATA2;
          end
          S_WAIT_DATA2: state <= S_WAIT_DATA1;
          default:      state <= S_WAIT_STATUS;
        endcase
      end
    end
  end

  midi_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push_evt),
    .din    (new_evt),
    .pop    (pop_evt),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .head   (head_evt)
  );

  assign note_on_out  = head_evt.note_on;
  assign note_num_out = head_evt.note_num;
  assign velocity_out = head_evt.velocity;

endmodule
